// File: rtl/core_pkg.sv
// Shared types for the run/halt sequencer of the 9-bit-ISA core.
package core_pkg;

   // ISA instruction word width
   localparam int IW = 9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } run_state_t;

   typedef enum logic [1:0] {
      HR_NONE    = 2'b00,
      HR_PCEND   = 2'b01,
      HR_HALTW   = 2'b10,
      HR_TIMEOUT = 2'b11
   } halt_reason_t;

   // Halt conditions seen in the current RUN cycle (already qualified by core_en)
   typedef struct packed {
      logic pc_end;
      logic halt_word;
      logic timeout;
   } halt_hits_t;

   // Priority encode the halt conditions: PC_END > halt word > timeout
   function automatic halt_reason_t pick_reason(input halt_hits_t hits);
      halt_reason_t r;
      if (hits.pc_end)
         r = HR_PCEND;
      else if (hits.halt_word)
         r = HR_HALTW;
      else if (hits.timeout)
         r = HR_TIMEOUT;
      else
         r = HR_NONE;
      return r;
   endfunction

endpackage

// File: rtl/core_run_ctrl_if.sv
// Handshake/status bundle between the run sequencer and the rest of the top level.
interface core_run_ctrl_if #(
   parameter int PC_W  = 8,
   parameter int IW    = core_pkg::IW,
   parameter int CYC_W = 16
);
   logic             start;
   logic             pause;
   logic [PC_W-1:0]  pc;
   logic [IW-1:0]    mach_code;
   logic             core_clear;
   logic             core_en;
   logic             busy;
   logic             done;
   logic [1:0]       halt_reason;
   logic [CYC_W-1:0] cycle_count;
   logic [CYC_W-1:0] instr_count;

   // The sequencer itself
   modport master (
      input  start, pause, pc, mach_code,
      output core_clear, core_en, busy, done, halt_reason, cycle_count, instr_count
   );

   // The environment: start/pause source, PC and instruction memory, status sink
   modport slave (
      output start, pause, pc, mach_code,
      input  core_clear, core_en, busy, done, halt_reason, cycle_count, instr_count
   );
endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and saturation at MAX; never wraps.
module sat_counter #(
   parameter int           W   = 8,
   parameter logic [W-1:0] MAX = {W{1'b1}}
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         en,
   output logic [W-1:0] count
);

   // Clear wins over enable; stop counting once MAX is reached
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (en && (count < MAX))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/core_run_ctrl.sv
// Run/halt sequencer: start/done handshake, one-cycle core clear, run/pause
// gating of the core and halt detection with reason reporting.
module core_run_ctrl
   import core_pkg::*;
#(
   parameter int              PC_W      = 8,
   parameter int              IW        = core_pkg::IW,
   parameter logic [IW-1:0]   HALT_CODE = '0,
   parameter int              HALT_CNT  = 2,
   parameter logic [PC_W-1:0] PC_END    = {PC_W{1'b1}},
   parameter int              CYC_W     = 16,
   parameter logic [CYC_W-1:0] MAX_CYC  = {CYC_W{1'b1}}
) (
   input logic             clk,
   input logic             reset,
   core_run_ctrl_if.master bus
);

   // Run-length counter only needs to reach HALT_CNT
   localparam int              RL_W   = $clog2(HALT_CNT + 1);
   localparam logic [RL_W-1:0] RL_MAX = RL_W'(HALT_CNT);

   run_state_t   state_reg, state_next;
   logic         start_q, start_armed, start_rise;
   logic         run_en, in_clear, is_halt_word, any_hit;
   halt_hits_t   hits;
   halt_reason_t hit_reason;

   logic         core_clear_reg, core_clear_next;
   logic         busy_reg, busy_next;
   logic         done_reg, done_next;
   halt_reason_t halt_reason_reg, halt_reason_next;

   logic [1:0]       cnt_en;
   logic [CYC_W-1:0] cnt_val [2];
   logic [RL_W-1:0]  run_len;
   logic             run_len_clear, run_len_en;

   // Track start for edge detection; a level already high across reset must
   // go low once before it can count as a new request
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         start_q     <= 1'b0;
         start_armed <= 1'b0;
      end else begin
         start_q <= bus.start;
         if (!bus.start)
            start_armed <= 1'b1;
      end
   end

   assign start_rise = bus.start & ~start_q & start_armed;

   // core_en is the only combinational output: RUN and not paused
   assign run_en   = (state_reg == RUN) && !bus.pause;
   assign in_clear = (state_reg == CLEAR);

   // Cycle counter (every RUN cycle) and instruction counter (core_en cycles)
   assign cnt_en[0] = (state_reg == RUN);
   assign cnt_en[1] = run_en;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
         sat_counter #(.W(CYC_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clear (in_clear),
            .en    (cnt_en[gi]),
            .count (cnt_val[gi])
         );
      end
   endgenerate

   // Halt-word run length: holds while paused, restarts on any other word
   assign is_halt_word  = (bus.mach_code == HALT_CODE);
   assign run_len_en    = run_en && is_halt_word;
   assign run_len_clear = in_clear || (run_en && !is_halt_word);

   sat_counter #(.W(RL_W), .MAX(RL_MAX)) u_run_len (
      .clk   (clk),
      .reset (reset),
      .clear (run_len_clear),
      .en    (run_len_en),
      .count (run_len)
   );

   // Halt decode: conditions look at the value the counters reach this cycle,
   // so the halting cycle is itself counted and the counters stop at the limit
   always_comb begin
      hits           = '0;
      hits.pc_end    = run_en && (bus.pc == PC_END);
      hits.halt_word = run_len_en && (({1'b0, run_len} + 1'b1) >= {1'b0, RL_MAX});
      hits.timeout   = run_en && (({1'b0, cnt_val[0]} + 1'b1) >= {1'b0, MAX_CYC});
   end

   assign any_hit    = |hits;
   assign hit_reason = pick_reason(hits);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Next-state logic; start edges in CLEAR/RUN are dropped, not queued
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start_rise) state_next = CLEAR;
         CLEAR:   state_next = RUN;
         RUN:     if (any_hit) state_next = DONE;
         DONE:    if (start_rise) state_next = CLEAR;
         default: state_next = IDLE;
      endcase
   end

   // Next values of the registered outputs
   always_comb begin
      core_clear_next  = (state_next == CLEAR);
      busy_next        = (state_next == CLEAR) || (state_next == RUN);
      done_next        = done_reg;
      halt_reason_next = halt_reason_reg;
      case (state_reg)
         CLEAR: begin
            done_next        = 1'b0;
            halt_reason_next = HR_NONE;
         end
         RUN: begin
            if (any_hit) begin
               done_next        = 1'b1;
               halt_reason_next = hit_reason;
            end
         end
         default: ;
      endcase
   end

   // Output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         core_clear_reg  <= 1'b0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
         halt_reason_reg <= HR_NONE;
      end else begin
         core_clear_reg  <= core_clear_next;
         busy_reg        <= busy_next;
         done_reg        <= done_next;
         halt_reason_reg <= halt_reason_next;
      end
   end

   assign bus.core_clear  = core_clear_reg;
   assign bus.core_en     = run_en;
   assign bus.busy        = busy_reg;
   assign bus.done        = done_reg;
   assign bus.halt_reason = halt_reason_reg;
   assign bus.cycle_count = cnt_val[0];
   assign bus.instr_count = cnt_val[1];

endmodule

// File: tb/tb_core_run_ctrl.sv
// Self-checking bench for core_run_ctrl: scripted runs, scoreboard of
// expected end-of-run results checked when done rises.
module tb_core_run_ctrl;
   import core_pkg::*;

   localparam int PC_W  = 8;
   localparam int CYC_W = 16;

   typedef struct {
      logic [1:0]  reason;
      logic [15:0] cyc;
      logic [15:0] ins;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;
   int   run_no = 0;

   logic clk = 1'b0;
   logic reset;
   logic done_prev = 1'b0;

   always #5 clk = ~clk;

   core_run_ctrl_if #(.PC_W(PC_W), .IW(IW), .CYC_W(CYC_W)) bus ();

   core_run_ctrl #(
      .PC_W(PC_W), .IW(IW), .HALT_CODE(9'h000), .HALT_CNT(2),
      .PC_END(8'hFF), .CYC_W(CYC_W), .MAX_CYC(16'd20)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard: compare end-of-run status when done rises
   always @(negedge clk) begin
      if (bus.done && !done_prev) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_done", 32'(sb_q.size()), 32'd1);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            run_no++;
            $display("run %0d: reason=%0d cycles=%0d instrs=%0d (exp %0d/%0d/%0d)",
                     run_no, bus.halt_reason, bus.cycle_count, bus.instr_count,
                     e.reason, e.cyc, e.ins);
            chk("sb_reason", 32'(bus.halt_reason), 32'(e.reason));
            chk("sb_cycles", 32'(bus.cycle_count), 32'(e.cyc));
            chk("sb_instrs", 32'(bus.instr_count), 32'(e.ins));
         end
      end
      done_prev <= bus.done;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] p, input logic [8:0] mc, input logic pz);
      bus.pc        = p;
      bus.mach_code = mc;
      bus.pause     = pz;
      #1;
   endtask

   // One RUN cycle: apply inputs, check core_en follows pause, advance
   task automatic rc(input logic [7:0] p, input logic [8:0] mc, input logic pz);
      drive(p, mc, pz);
      chk("core_en", 32'(bus.core_en), 32'(!pz));
      tick();
   endtask

   // Raise start (pause held high to show it is ignored outside RUN),
   // then check the CLEAR cycle and the first RUN cycle
   task automatic begin_run(input bit keep_start, input logic exp_done_in_clear);
      bus.start = 1'b1;
      drive(8'h00, 9'h1AA, 1'b1);
      tick();
      chk("clear_pulse", 32'(bus.core_clear), 32'd1);
      chk("clear_busy", 32'(bus.busy), 32'd1);
      chk("clear_done", 32'(bus.done), 32'(exp_done_in_clear));
      chk("clear_core_en", 32'(bus.core_en), 32'd0);
      if (!keep_start)
         bus.start = 1'b0;
      tick();
      chk("clear_one_cycle", 32'(bus.core_clear), 32'd0);
      chk("run_done_low", 32'(bus.done), 32'd0);
      chk("run_cyc_zero", 32'(bus.cycle_count), 32'd0);
      chk("run_ins_zero", 32'(bus.instr_count), 32'd0);
      chk("run_reason_zero", 32'(bus.halt_reason), 32'd0);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_clear"}, 32'(bus.core_clear), 32'd0);
      chk({tag, "_en"}, 32'(bus.core_en), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_done"}, 32'(bus.done), 32'd0);
      chk({tag, "_reason"}, 32'(bus.halt_reason), 32'd0);
      chk({tag, "_cyc"}, 32'(bus.cycle_count), 32'd0);
      chk({tag, "_ins"}, 32'(bus.instr_count), 32'd0);
   endtask

   initial begin
      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.pause     = 1'b0;
      bus.pc        = '0;
      bus.mach_code = '0;
      tick();
      tick();
      check_idle_outputs("reset");
      reset = 1'b0;
      tick();

      // 1. halt word: five ordinary words then two halt words
      sb_q.push_back('{reason: 2'b10, cyc: 16'd7, ins: 16'd7});
      begin_run(1'b0, 1'b0);
      for (int i = 0; i < 5; i++)
         rc(8'(i + 1), 9'h0A5 + 9'(i), 1'b0);
      rc(8'd6, 9'h000, 1'b0);
      chk("t1_one_halt_word", 32'(bus.done), 32'd0);
      rc(8'd7, 9'h000, 1'b0);
      chk("t1_done", 32'(bus.done), 32'd1);
      chk("t1_en_drop", 32'(bus.core_en), 32'd0);
      chk("t1_busy", 32'(bus.busy), 32'd0);
      tick();

      // 2. terminal PC coinciding with a completing halt word
      sb_q.push_back('{reason: 2'b01, cyc: 16'd4, ins: 16'd4});
      begin_run(1'b0, 1'b1);
      rc(8'd1, 9'h011, 1'b0);
      rc(8'd2, 9'h022, 1'b0);
      rc(8'd3, 9'h000, 1'b0);
      chk("t2_no_halt_yet", 32'(bus.done), 32'd0);
      rc(8'hFF, 9'h000, 1'b0);
      chk("t2_done", 32'(bus.done), 32'd1);
      chk("t2_reason", 32'(bus.halt_reason), 32'd1);
      tick();

      // 3. pause with halt words under pause, plus a start edge during RUN
      sb_q.push_back('{reason: 2'b10, cyc: 16'd9, ins: 16'd3});
      begin_run(1'b0, 1'b1);
      rc(8'd1, 9'h033, 1'b0);
      bus.start = 1'b1;
      rc(8'd2, 9'h000, 1'b1);
      chk("t3_start_ignored_clear", 32'(bus.core_clear), 32'd0);
      chk("t3_start_ignored_busy", 32'(bus.busy), 32'd1);
      rc(8'd2, 9'h000, 1'b1);
      bus.start = 1'b0;
      rc(8'd2, 9'h000, 1'b1);
      rc(8'd2, 9'h000, 1'b1);
      chk("t3_pause_cyc", 32'(bus.cycle_count), 32'd5);
      chk("t3_pause_ins", 32'(bus.instr_count), 32'd1);
      rc(8'd3, 9'h000, 1'b0);
      chk("t3_len_held", 32'(bus.done), 32'd0);
      rc(8'd4, 9'h000, 1'b1);
      rc(8'd4, 9'h000, 1'b1);
      chk("t3_no_halt_paused", 32'(bus.done), 32'd0);
      rc(8'd4, 9'h000, 1'b0);
      chk("t3_done", 32'(bus.done), 32'd1);
      tick();

      // 4. timeout at 20 cycles, start held high through the whole run
      sb_q.push_back('{reason: 2'b11, cyc: 16'd20, ins: 16'd20});
      begin_run(1'b1, 1'b1);
      for (int i = 0; i < 20; i++) begin
         chk("t4_running", 32'(bus.done), 32'd0);
         rc(8'(i + 16), 9'h055, 1'b0);
      end
      chk("t4_done", 32'(bus.done), 32'd1);
      chk("t4_reason", 32'(bus.halt_reason), 32'd3);

      // 5. start still high in DONE: no new run, counters frozen
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t5_stay_done", 32'(bus.done), 32'd1);
         chk("t5_no_clear", 32'(bus.core_clear), 32'd0);
         chk("t5_frozen_cyc", 32'(bus.cycle_count), 32'd20);
      end
      bus.start = 1'b0;
      tick();
      begin_run(1'b0, 1'b1);
      rc(8'd1, 9'h044, 1'b0);
      rc(8'd2, 9'h045, 1'b0);
      chk("t5_rerun_cyc", 32'(bus.cycle_count), 32'd2);

      // 6. asynchronous reset mid-RUN with start held high afterwards
      bus.start = 1'b1;
      drive(8'd3, 9'h046, 1'b0);
      reset = 1'b1;
      #1;
      check_idle_outputs("t6_async");
      tick();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t6_no_start_busy", 32'(bus.busy), 32'd0);
         chk("t6_no_start_clear", 32'(bus.core_clear), 32'd0);
      end
      bus.start = 1'b0;
      tick();
      sb_q.push_back('{reason: 2'b01, cyc: 16'd2, ins: 16'd2});
      begin_run(1'b0, 1'b0);
      rc(8'd1, 9'h077, 1'b0);
      rc(8'hFF, 9'h078, 1'b0);
      chk("t6_done", 32'(bus.done), 32'd1);
      tick();
      tick();

      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
